vector_reconstruct: RTL and testbench
=====================================

Name: vector_reconstruct

Overview:
- Inverse of the ball-vector stage: takes a red-ball anchor position and N_TRACKING_POINTS-1 signed offset vectors, and rebuilds the absolute screen coordinates of each tracked point.
- Emits the points serially, one per accepted handshake, for the downstream overlay/rendering logic.
- Each output coordinate is clamped to the visible frame and carries a clip flag.

Parameters:
N_TRACKING_POINTS, 4, tracked balls including the anchor; block emits N_TRACKING_POINTS-1 points
H_MAX, 1279, largest legal x coordinate
V_MAX, 719, largest legal y coordinate
Define IW = $clog2(N_TRACKING_POINTS) (2 at default).

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous, active-high reset
start_in  input  1  request to reconstruct; sampled only in IDLE
anchor_x_in  input  11  anchor (red) x, unsigned
anchor_y_in  input  10  anchor (red) y, unsigned
vectors_x_in  input  signed [N_TRACKING_POINTS-2:0][15:0]  x offsets from the anchor
vectors_y_in  input  signed [N_TRACKING_POINTS-2:0][15:0]  y offsets from the anchor
point_x_out  output  11  reconstructed x, clamped
point_y_out  output  10  reconstructed y, clamped
point_idx_out  output  IW  index of the vector producing the current point
point_clipped_out  output  1  either axis was clamped for this point
point_valid_out  output  1  point outputs are valid
point_ready_in  input  1  downstream accepts the point
busy_out  output  1  block is not in IDLE
done_out  output  1  one-cycle pulse after the last point is accepted

Behaviour:
- Interface: one clock, clk_in. Reset rst_in is asynchronous and active-high.
- Reset: all outputs go to 0 immediately. State goes to IDLE. Captured registers and the index clear.
- Reset asserted mid-EMIT aborts the sequence. No done_out is produced. The first point after release requires a new start_in.
- All outputs are registered.
- States: IDLE, EMIT, DONE.
- IDLE:
  - start_in=1 at edge k captures the anchor and all vectors, and sets index=0.
  - Point 0 is loaded into the output registers from the live inputs at the same edge.
  - State goes to EMIT. From k+1: point_valid_out=1, busy_out=1.
  - start_in=0: outputs hold 0/idle.
- EMIT:
  - A handshake occurs on point_valid_out && point_ready_in at a rising edge.
  - Outputs are held stable while valid && !ready. This holds for any number of cycles.
  - On handshake with index < N_TRACKING_POINTS-2: index++, and the next point is loaded from the captured registers. point_valid_out stays 1, so there is no bubble.
  - On handshake with index = N_TRACKING_POINTS-2: point_valid_out goes to 0, state goes to DONE.
- DONE:
  - done_out=1 and busy_out=1 for exactly one cycle.
  - Then IDLE: done_out=0, busy_out=0.
- start_in is ignored in EMIT and DONE. Captured data is never overwritten mid-sequence.
- Throughput: with point_ready_in tied high, points appear at k+1..k+3, done_out at k+4, and a new start is accepted at k+5.
- Arithmetic, per axis:
  - sum = signed 17-bit, equal to {6'b0, anchor_x} + sign-extended vector_x; y uses {7'b0, anchor_y}.
  - sum < 0 -> output 0, clipped.
  - sum > H_MAX (x) or > V_MAX (y) -> output the max, clipped.
  - Otherwise output sum[10:0] / sum[9:0].
  - point_clipped_out = x-clip OR y-clip.
  - Vectors up to ±32767 must clamp correctly with no wrap.
- After the last handshake, point_x/y/idx/clipped keep their last values. They are don't-care while point_valid_out=0.

Test Plan:
- Basic reconstruction:
  - Stimulus: reset; anchor (100,200); vectors_x {50,-30,0}, vectors_y {-10,20,5}; start pulse; ready=1.
  - Required: valid points (150,190,idx0), (70,220,idx1), (100,205,idx2) on 3 consecutive cycles; clipped=0; done_out pulse on the next cycle; busy_out falls after it.
- Low clamp:
  - Stimulus: anchor (10,5); vector0 (-20,-10).
  - Required: point0 = (0,0), clipped=1.
  - Stimulus: vector0 (-32768,0).
  - Required: x=0, y=5, clipped=1.
- High clamp:
  - Stimulus: anchor (1270,710); vector1 (+20,+20).
  - Required: point1 = (1279,719), clipped=1.
  - Stimulus: vector2 (+9,+9).
  - Required: (1279,719), clipped=0.
- Backpressure:
  - Stimulus: ready held low 3 cycles while point1 is presented.
  - Required: outputs and idx=1 stable for all 3 cycles; raising ready advances to idx2; total of exactly 3 handshakes.
- Start ignored while busy:
  - Stimulus: a second start_in with different anchor values during EMIT and during DONE.
  - Required: emitted points use the original capture; exactly one done_out per accepted start.
- Asynchronous reset mid-EMIT:
  - Stimulus: assert rst_in between clock edges after point0 is accepted.
  - Required: point_valid_out, busy_out and done_out drop to 0 immediately without a clock edge; no done_out pulse follows; after release, a fresh start produces idx0 first.

Source files
------------

// File: rtl/vector_reconstruct.sv
// Rebuilds absolute point coordinates from a captured anchor and signed offset vectors,
// emitting one clamped point per valid/ready handshake.
module vector_reconstruct #(
  parameter int N_TRACKING_POINTS = 4,
  parameter int H_MAX = 1279,
  parameter int V_MAX = 719,
  localparam int IW = $clog2(N_TRACKING_POINTS)
) (
  input  logic                                       clk_in,
  input  logic                                       rst_in,
  input  logic                                       start_in,
  input  logic [10:0]                                anchor_x_in,
  input  logic [9:0]                                 anchor_y_in,
  input  logic signed [N_TRACKING_POINTS-2:0][15:0]  vectors_x_in,
  input  logic signed [N_TRACKING_POINTS-2:0][15:0]  vectors_y_in,
  output logic [10:0]                                point_x_out,
  output logic [9:0]                                 point_y_out,
  output logic [IW-1:0]                              point_idx_out,
  output logic                                       point_clipped_out,
  output logic                                       point_valid_out,
  input  logic                                       point_ready_in,
  output logic                                       busy_out,
  output logic                                       done_out
);

  localparam logic [IW-1:0]      LAST_IDX = IW'(N_TRACKING_POINTS - 2);
  localparam logic signed [16:0] H_LIM    = 17'(H_MAX);
  localparam logic signed [16:0] V_LIM    = 17'(V_MAX);
  localparam logic [10:0]        H_MAX_X  = 11'(H_MAX);
  localparam logic [9:0]         V_MAX_Y  = 10'(V_MAX);

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  state_t state;

  logic [10:0]                               anchor_x_q;
  logic [9:0]                                anchor_y_q;
  logic signed [N_TRACKING_POINTS-2:0][15:0] vec_x_q;
  logic signed [N_TRACKING_POINTS-2:0][15:0] vec_y_q;

  logic [IW-1:0]      nxt_idx;
  logic [10:0]        src_ax;
  logic [9:0]         src_ay;
  logic [15:0]        src_vx;
  logic [15:0]        src_vy;
  logic signed [16:0] sum_x;
  logic signed [16:0] sum_y;
  logic [10:0]        cand_x;
  logic [9:0]         cand_y;
  logic               clip_x;
  logic               clip_y;
  logic               handshake;

  // In IDLE point 0 comes straight from the live inputs; afterwards from the captured copy.
  always_comb begin
    nxt_idx = (point_idx_out == LAST_IDX) ? point_idx_out : point_idx_out + IW'(1);
    src_ax  = anchor_x_q;
    src_ay  = anchor_y_q;
    src_vx  = vec_x_q[nxt_idx];
    src_vy  = vec_y_q[nxt_idx];
    if (state == IDLE) begin
      src_ax = anchor_x_in;
      src_ay = anchor_y_in;
      src_vx = vectors_x_in[0];
      src_vy = vectors_y_in[0];
    end

    sum_x = $signed({6'b0, src_ax}) + $signed({src_vx[15], src_vx});
    sum_y = $signed({7'b0, src_ay}) + $signed({src_vy[15], src_vy});

    clip_x = 1'b0;
    cand_x = sum_x[10:0];
    if (sum_x[16]) begin
      clip_x = 1'b1;
      cand_x = '0;
    end else if (sum_x > H_LIM) begin
      clip_x = 1'b1;
      cand_x = H_MAX_X;
    end

    clip_y = 1'b0;
    cand_y = sum_y[9:0];
    if (sum_y[16]) begin
      clip_y = 1'b1;
      cand_y = '0;
    end else if (sum_y > V_LIM) begin
      clip_y = 1'b1;
      cand_y = V_MAX_Y;
    end

    handshake = point_valid_out & point_ready_in;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state             <= IDLE;
      anchor_x_q        <= '0;
      anchor_y_q        <= '0;
      vec_x_q           <= '0;
      vec_y_q           <= '0;
      point_x_out       <= '0;
      point_y_out       <= '0;
      point_idx_out     <= '0;
      point_clipped_out <= 1'b0;
      point_valid_out   <= 1'b0;
      busy_out          <= 1'b0;
      done_out          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_out <= 1'b0;
          if (start_in) begin
            anchor_x_q        <= anchor_x_in;
            anchor_y_q        <= anchor_y_in;
            vec_x_q           <= vectors_x_in;
            vec_y_q           <= vectors_y_in;
            point_idx_out     <= '0;
            point_x_out       <= cand_x;
            point_y_out       <= cand_y;
            point_clipped_out <= clip_x | clip_y;
            point_valid_out   <= 1'b1;
            busy_out          <= 1'b1;
            state             <= EMIT;
          end
        end
        EMIT: begin
          if (handshake) begin
            if (point_idx_out == LAST_IDX) begin
              point_valid_out <= 1'b0;
              done_out        <= 1'b1;
              state           <= DONE;
            end else begin
              point_idx_out     <= nxt_idx;
              point_x_out       <= cand_x;
              point_y_out       <= cand_y;
              point_clipped_out <= clip_x | clip_y;
            end
          end
        end
        DONE: begin
          done_out <= 1'b0;
          busy_out <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_reconstruct.sv
// Scoreboard bench for vector_reconstruct: stimulus pushes hand-computed points,
// a negedge monitor pops and compares on every presented point.
module tb_vector_reconstruct;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic [10:0]              anchor_x;
  logic [9:0]               anchor_y;
  logic signed [2:0][15:0]  vx;
  logic signed [2:0][15:0]  vy;
  logic [10:0]              px;
  logic [9:0]               py;
  logic [1:0]               pidx;
  logic                     pclip;
  logic                     pvalid;
  logic                     pready;
  logic                     busy;
  logic                     done;

  typedef struct {int x; int y; int idx; int clip;} exp_t;
  exp_t sb[$];
  exp_t e;

  int checks = 0;
  int errors = 0;
  int done_count = 0;
  int hs_count = 0;

  vector_reconstruct dut (
    .clk_in(clk), .rst_in(rst), .start_in(start),
    .anchor_x_in(anchor_x), .anchor_y_in(anchor_y),
    .vectors_x_in(vx), .vectors_y_in(vy),
    .point_x_out(px), .point_y_out(py), .point_idx_out(pidx),
    .point_clipped_out(pclip), .point_valid_out(pvalid),
    .point_ready_in(pready), .busy_out(busy), .done_out(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_count++;
      if (pvalid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_point: got idx %0d, expected no point", pidx);
        end else begin
          e = sb[0];
          check("point_x", int'(px), e.x);
          check("point_y", int'(py), e.y);
          check("point_idx", int'(pidx), e.idx);
          check("point_clipped", int'(pclip), e.clip);
          if (pready) begin
            void'(sb.pop_front());
            hs_count++;
          end
        end
      end
    end
  end

  task automatic set_in(input int ax, input int ay, input int x0, input int x1, input int x2,
                        input int y0, input int y1, input int y2);
    anchor_x = 11'(ax);
    anchor_y = 10'(ay);
    vx[0] = 16'(x0); vx[1] = 16'(x1); vx[2] = 16'(x2);
    vy[0] = 16'(y0); vy[1] = 16'(y1); vy[2] = 16'(y2);
  endtask

  task automatic push(input int x, input int y, input int i, input int c);
    sb.push_back(exp_t'{x, y, i, c});
  endtask

  // Returns 1ns after the edge that samples start.
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int base;
    int n;
    base = done_count;
    n = 0;
    while (done_count == base && n < 100) begin
      @(posedge clk);
      n++;
    end
    check(name, int'(done_count != base), 1);
    repeat (2) @(posedge clk);
    #1;
    check({name, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    int hs_base;
    int dc_base;
    rst = 1'b1; start = 1'b0; pready = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    check("rst_valid", int'(pvalid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_x", int'(px), 0);
    check("rst_idx", int'(pidx), 0);
    #10 rst = 1'b0;

    // basic reconstruction with cycle-exact timing
    set_in(100, 200, 50, -30, 0, -10, 20, 5);
    push(150, 190, 0, 0); push(70, 220, 1, 0); push(100, 205, 2, 0);
    hs_base = hs_count;
    pulse_start();
    check("basic_valid_k1", int'(pvalid), 1);
    check("basic_busy_k1", int'(busy), 1);
    @(posedge clk); #1 check("basic_valid_k2", int'(pvalid), 1);
    @(posedge clk); #1 check("basic_valid_k3", int'(pvalid), 1);
    @(posedge clk); #1;
    check("basic_done_k4", int'(done), 1);
    check("basic_busy_k4", int'(busy), 1);
    check("basic_valid_k4", int'(pvalid), 0);
    @(posedge clk); #1;
    check("basic_done_k5", int'(done), 0);
    check("basic_busy_k5", int'(busy), 0);
    check("basic_handshakes", hs_count - hs_base, 3);
    check("basic_sb_empty", sb.size(), 0);

    // low clamp
    set_in(10, 5, -20, 0, 0, -10, 0, 0);
    push(0, 0, 0, 1); push(10, 5, 1, 0); push(10, 5, 2, 0);
    pulse_start();
    wait_done("low_clamp");
    set_in(10, 5, -32768, 0, 0, 0, 0, 0);
    push(0, 5, 0, 1); push(10, 5, 1, 0); push(10, 5, 2, 0);
    pulse_start();
    wait_done("low_clamp_min");

    // high clamp and exact edge
    set_in(1270, 710, 0, 20, 9, 0, 20, 9);
    push(1270, 710, 0, 0); push(1279, 719, 1, 1); push(1279, 719, 2, 0);
    pulse_start();
    wait_done("high_clamp");
    set_in(1270, 710, 32767, 0, 0, -32768, 0, 0);
    push(1279, 0, 0, 1); push(1270, 710, 1, 0); push(1270, 710, 2, 0);
    pulse_start();
    wait_done("extreme_clamp");

    // backpressure on point1
    set_in(100, 200, 50, -30, 0, -10, 20, 5);
    push(150, 190, 0, 0); push(70, 220, 1, 0); push(100, 205, 2, 0);
    hs_base = hs_count;
    pulse_start();
    @(posedge clk); #1 pready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("bp_idx_held", int'(pidx), 1);
    check("bp_valid_held", int'(pvalid), 1);
    pready = 1'b1;
    wait_done("backpressure");
    check("bp_handshakes", hs_count - hs_base, 3);

    // start ignored during EMIT and DONE
    set_in(100, 200, 50, -30, 0, -10, 20, 5);
    push(150, 190, 0, 0); push(70, 220, 1, 0); push(100, 205, 2, 0);
    dc_base = done_count;
    pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    set_in(500, 400, 1, 1, 1, 1, 1, 1);
    repeat (3) @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("busy_start_done_once", done_count - dc_base, 1);
    check("busy_start_idle", int'(busy), 0);
    check("busy_start_sb_empty", sb.size(), 0);

    // asynchronous reset mid-EMIT
    set_in(100, 200, 50, -30, 0, -10, 20, 5);
    push(150, 190, 0, 0); push(70, 220, 1, 0); push(100, 205, 2, 0);
    pulse_start();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_valid", int'(pvalid), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_done", int'(done), 0);
    sb.delete();
    dc_base = done_count;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("arst_no_done", done_count - dc_base, 0);
    check("arst_idle_valid", int'(pvalid), 0);
    set_in(200, 100, 5, 6, 7, -5, -6, -7);
    push(205, 95, 0, 0); push(206, 94, 1, 0); push(207, 93, 2, 0);
    pulse_start();
    wait_done("arst_restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
